out_matrix_reader: RTL and testbench

Read-side companion to the output-matrix accumulator. On a start pulse it snapshots the full N×N result matrix, then streams it out one element per beat over a valid/ready handshake. Each element carries the same byte address the accumulator's write window decodes. It sits between the matrix result store and the downstream display/host interface.

---
 rtl/out_matrix_reader.sv | 134 +++++++++++++
 tb/tb_out_matrix_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_matrix_reader.sv
// out_matrix_reader
//   Snapshots the N x N result matrix on a start request and streams it out
//   one element per beat over a valid/ready handshake. Each beat carries the
//   element value and its byte address in the accumulator window
//   (OFFCET + row*N + col, truncated to 10 bits).
//
// Ports
//   clk        system clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   all        live matrix from the accumulator, indexed [row][col]
//   start      one-cycle transfer request, honoured only when idle
//   col_major  order select sampled with start (0 row-major, 1 column-major)
//   out_ready  downstream accepts the current beat
//   out_data   element value of the current beat
//   out_addr   element address of the current beat
//   out_valid  beat present
//   out_last   current beat is the final element
//   busy       transfer in progress (start acceptance until done)
//   done       one-cycle pulse after the last beat is accepted
module out_matrix_reader #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned N      = 8,
  parameter int unsigned OFFCET = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N-1:0][N-1:0][BITS-1:0]  all,
  input  logic                           start,
  input  logic                           col_major,
  input  logic                           out_ready,
  output logic [BITS-1:0]                out_data,
  output logic [9:0]                     out_addr,
  output logic                           out_valid,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state;
  logic [N-1:0][N-1:0][BITS-1:0] snap;
  logic [CW-1:0]                 row;
  logic [CW-1:0]                 col;
  logic [CW-1:0]                 nrow;
  logic [CW-1:0]                 ncol;
  logic                          cm;

  // Position of the element that follows the current one in the latched order.
  always_comb begin
    nrow = row;
    ncol = col;
    if (cm) begin
      if (row == LAST_IDX) begin
        nrow = '0;
        ncol = col + CW'(1);
      end else begin
        nrow = row + CW'(1);
      end
    end else begin
      if (col == LAST_IDX) begin
        ncol = '0;
        nrow = row + CW'(1);
      end else begin
        ncol = col + CW'(1);
      end
    end
  end

  // Outputs are loaded one beat ahead from the snapshot so every output is a
  // plain register; out_ready only steers which value gets loaded next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      snap      <= '0;
      row       <= '0;
      col       <= '0;
      cm        <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap      <= all;
            cm        <= col_major;
            row       <= '0;
            col       <= '0;
            out_data  <= all[0][0];
            out_addr  <= 10'(OFFCET);
            out_valid <= 1'b1;
            out_last  <= (N == 1);
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              row      <= nrow;
              col      <= ncol;
              out_data <= snap[nrow][ncol];
              out_addr <= 10'(OFFCET + N * 32'(nrow) + 32'(ncol));
              out_last <= (nrow == LAST_IDX) && (ncol == LAST_IDX);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_matrix_reader.sv
module tb_out_matrix_reader;
  localparam int BITS   = 8;
  localparam int N      = 8;
  localparam int OFFCET = 64;

  logic                          clk = 1'b0;
  logic                          rst = 1'b0;
  logic                          start = 1'b0;
  logic                          col_major = 1'b0;
  logic                          out_ready = 1'b0;
  logic [N-1:0][N-1:0][BITS-1:0] all;
  logic [BITS-1:0]               out_data;
  logic [9:0]                    out_addr;
  logic                          out_valid;
  logic                          out_last;
  logic                          busy;
  logic                          done;

  out_matrix_reader #(.BITS(BITS), .N(N), .OFFCET(OFFCET)) dut (
    .clk(clk), .rst(rst), .all(all), .start(start), .col_major(col_major),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [9:0] a;
    logic       l;
  } beat_t;

  beat_t exp_q[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    accepted   = 0;
  int    done_cnt   = 0;
  bit    rnd_ready  = 0;
  bit    ready_lvl  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Ready driver: changes only 1 ns after the rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
  end

  // Monitor: pops the scoreboard on every accepted beat, checks stall stability
  // and the done pulse that must follow the last beat.
  initial begin
    bit         prev_stall;
    bit         prev_last;
    logic [7:0] held_d;
    logic [9:0] held_a;
    beat_t      e;
    prev_stall = 0;
    prev_last  = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 0;
        prev_last  = 0;
      end else begin
        if (done) done_cnt++;
        if (prev_last) begin
          check("done_after_last", done, 1);
          check("valid_after_last", out_valid, 0);
        end
        prev_last = 0;
        if (prev_stall && out_valid) begin
          check("stall_data", out_data, held_d);
          check("stall_addr", out_addr, held_a);
        end
        prev_stall = 0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL extra_beat: got addr %0h data %0h, expected no beat", out_addr, out_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", out_data, e.d);
            check("beat_addr", out_addr, e.a);
            check("beat_last", out_last, e.l);
          end
          accepted++;
          if (out_last) prev_last = 1;
        end else if (out_valid) begin
          prev_stall = 1;
          held_d     = out_data;
          held_a     = out_addr;
        end
      end
    end
  end

  function automatic logic [7:0] elem(input int r, input int c, input bit inv);
    return inv ? 8'(255 - (r * 8 + c)) : 8'(r * 8 + c);
  endfunction

  task automatic fill(input bit inv);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        all[r][c] = elem(r, c, inv);
  endtask

  task automatic push_exp(input bit cm, input bit inv);
    beat_t e;
    int    r;
    int    c;
    for (int i = 0; i < N * N; i++) begin
      if (cm) begin c = i / 8; r = i % 8; end
      else    begin r = i / 8; c = i % 8; end
      e.d = elem(r, c, inv);
      e.a = 10'(OFFCET + r * 8 + c);
      e.l = (r == 7) && (c == 7);
      exp_q.push_back(e);
    end
  endtask

  // Start is raised after one edge and sampled on the next; returns 1 ns after
  // the accepting edge.
  task automatic pulse_start(input bit cm);
    @(posedge clk);
    #1;
    start     = 1'b1;
    col_major = cm;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_after_start", out_valid, 1);
    check("first_addr", out_addr, 10'(OFFCET));
  endtask

  task automatic wait_idle(input string name, input int d0, input int exp_cycles);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_busy_low"}, busy, 0);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_done_count"}, done_cnt - d0, 1);
    if (exp_cycles > 0) check({name, "_cycles"}, n, exp_cycles);
    exp_q.delete();
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (accepted < target && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("beat_wait", accepted >= target, 1);
  endtask

  initial begin
    int d0;
    fill(0);

    // Reset held, then idle with start low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle_outputs", {out_data, out_addr, out_valid, out_last, busy, done}, 0);
    end

    // Row-major, ready high.
    ready_lvl = 1;
    d0 = done_cnt;
    push_exp(0, 0);
    pulse_start(0);
    wait_idle("row_major", d0, 65);

    // Column-major, ready high.
    d0 = done_cnt;
    push_exp(1, 0);
    pulse_start(1);
    wait_idle("col_major", d0, 65);

    // Random backpressure, row-major.
    rnd_ready = 1;
    d0 = done_cnt;
    push_exp(0, 0);
    pulse_start(0);
    wait_idle("backpressure", d0, 0);
    rnd_ready = 0;
    repeat (2) @(posedge clk);

    // Snapshot isolation plus an ignored start mid-transfer.
    d0 = done_cnt;
    push_exp(0, 0);
    pulse_start(0);
    wait_beats(accepted + 9);
    fill(1);
    start     = 1'b1;
    col_major = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("no_restart_busy", busy, 1);
    wait_idle("isolation", d0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("no_queued_start", busy, 0);

    // Reset mid-transfer.
    fill(0);
    d0 = done_cnt;
    push_exp(0, 0);
    pulse_start(0);
    wait_beats(accepted + 19);
    #2;
    rst = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    exp_q.delete();
    check("abort_no_done", done_cnt - d0, 0);
    fill(1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    d0 = done_cnt;
    push_exp(0, 1);
    pulse_start(0);
    wait_idle("after_abort", d0, 65);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
